// File: rtl/local_inject_arbiter.sv
// Packet-granular round-robin arbiter that merges NREQ injecting sources onto one
// router local input port through a single registered valid/ready output stage.
module local_inject_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic                    noc_valid,
    input  logic                    noc_ready,
    output logic [DW-1:0]           noc_data,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err_proto,
    output logic                    err_timeout
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [SW-1:0] stall_cnt;

    logic [DW-1:0]   flit [NREQ];
    logic [NREQ-1:0] is_head;
    logic [NREQ-1:0] is_nonhead;

    // Split the flattened bus; the top flit bit set means head or single.
    for (genvar i = 0; i < int'(NREQ); i++) begin : g_split
        assign flit[i]       = req_data[i*DW +: DW];
        assign is_head[i]    = req_valid[i] &&  flit[i][DW-1];
        assign is_nonhead[i] = req_valid[i] && !flit[i][DW-1];
    end

    // First head-presenting requester at or after rr_ptr, wrapping.
    logic          pick_found;
    logic [IW-1:0] pick_id;
    int unsigned   idx;
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!pick_found && is_head[IW'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = IW'(idx);
            end
        end
    end

    logic [DW-1:0] g_flit;
    logic          g_valid;
    logic          g_last;
    logic          out_free;
    logic          accept;
    logic [IW-1:0] next_ptr;

    assign g_flit   = flit[grant_id];
    assign g_valid  = req_valid[grant_id];
    assign g_last   = g_flit[DW-2];
    assign out_free = !noc_valid || noc_ready;
    assign accept   = (state == LOCK) && g_valid && out_free;
    assign next_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

    // Only the locked requester sees ready, and only when the output slot frees up.
    always_comb begin
        req_ready = '0;
        if (state == LOCK) begin
            req_ready[grant_id] = out_free;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            stall_cnt   <= '0;
            noc_valid   <= 1'b0;
            noc_data    <= '0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (accept) begin
                noc_valid <= 1'b1;
                noc_data  <= g_flit;
            end else if (noc_ready) begin
                noc_valid <= 1'b0;
            end

            if ((state == IDLE) && (|is_nonhead)) begin
                err_proto <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_id;
                        state     <= LOCK;
                        busy      <= 1'b1;
                        stall_cnt <= '0;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        stall_cnt <= '0;
                        if (g_last) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                    end else if (!g_valid && (stall_cnt != STALL_MAX)) begin
                        // Only an absent source counts; router backpressure is not a stall.
                        stall_cnt <= stall_cnt + SW'(1);
                        if (stall_cnt == STALL_MAX - SW'(1)) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/local_inject_arbiter.md
# local_inject_arbiter

Shares one router local input port of the multicast cast network among NREQ injecting sources (drivers, PE output queues). Round-robin arbitration at packet granularity: a granted source holds the port from head flit to tail flit, so packets from different sources never interleave in the router. The block presents a single registered valid/ready/data stream to the router's local `data_i`/`valid_i`/`ready_o` triple. It also raises sticky error flags for protocol violations and stalled packets.

## Interface
- NREQ, 4: number of requesters, 2..16.
- DW, `` `DW ``: flit width from params.svh.
- TIMEOUT, 256: maximum idle cycles allowed inside a locked packet before `err_timeout` is set.

Ports:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester flit valid.
- req_ready  out  NREQ  per-requester flit accept.
- req_data  in  NREQ*DW  flattened flits; requester i occupies bits [i*DW +: DW].
- noc_valid  out  1  to router local `valid_i`.
- noc_ready  in  1  from router local `ready_o`.
- noc_data  out  DW  to router local `data_i`.
- grant_id  out  $clog2(NREQ)  currently locked requester; valid while `busy`=1.
- busy  out  1  packet lock held.
- err_proto  out  1  sticky flag: a non-head flit was presented by an ungranted requester.
- err_timeout  out  1  sticky flag: a locked packet stalled for TIMEOUT cycles.

## Operation
- Flit type is `data[DW-1:DW-2]`: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head and tail).
- The FSM has two states, IDLE and LOCK.
- IDLE:
  - Candidates are requesters with `req_valid`=1 and type head or single.
  - Pick the first candidate at or after `rr_ptr`, wrapping modulo NREQ. Register it into `grant_id` and go to LOCK next cycle.
  - `req_ready` is all-zero in IDLE; there is a one-cycle arbitration bubble per packet.
- LOCK:
  - `req_ready[grant_id] = !noc_valid || noc_ready`. All other `req_ready` bits are 0.
  - An accepted flit loads the output register.
  - Accepting a tail or single flit returns the FSM to IDLE and sets `rr_ptr = grant_id+1` (mod NREQ).
- Output register:
  - One entry. `noc_valid`/`noc_data` hold stable until `noc_ready`=1.
  - A new flit may load in the same cycle as the old one drains (full throughput in LOCK).
- err_proto:
  - Set when in IDLE with `req_valid[i]`=1 and type body or tail.
  - That requester is never granted until it presents a head flit. Other requesters are unaffected.
- err_timeout:
  - `stall_cnt` counts LOCK cycles with `req_valid[grant_id]`=0. It clears on any accepted flit and saturates at TIMEOUT.
  - Reaching TIMEOUT sets `err_timeout`. The lock is kept; no forced release.
- Backpressure does not count as stall: cycles where `req_valid`=1 but `req_ready`=0 because `noc_ready`=0 do not increment `stall_cnt`.
- Error flags clear only on reset.

## Timing
- Reset values: `req_ready`=0, `noc_valid`=0, `noc_data`=0, `grant_id`=0, `busy`=0, `err_proto`=0, `err_timeout`=0, `rr_ptr`=0, FSM=IDLE, `stall_cnt`=0.
- Latency, with router always ready:
  - Head `req_valid` sampled at cycle N (IDLE) -> grant at N+1 -> head accepted at N+1 -> `noc_valid` at N+2.
  - Body/tail flits follow one per cycle.
- `busy` is 1 from the cycle after the grant decision through the cycle the tail is accepted. The next IDLE cycle follows, so there is a minimum one-cycle gap between packets.
- Simultaneous events:
  - Tail accept and a new head at another requester in the same cycle: the new head is only arbitrated in the following IDLE cycle.
  - Tail drain (`noc_ready`) and tail load can coincide.
- Single requester streaming back-to-back single-flit packets: throughput is 1 flit per 2 cycles.
- Reset asserted mid-packet: all state clears immediately. A flit held in the output register is dropped; `noc_valid` falls asynchronously.
- `req_valid` may not drop once asserted until accepted (requester obligation). The block does not check this.

## Test plan
- Single packet: requester 2 sends head 0x2…A1, body, tail with `noc_ready`=1 -> `noc_valid` at cycle+2, three flits in order, `busy` 1 for 3 cycles, `rr_ptr`=3.
- Contention: requesters 0, 1, 3 each present a 2-flit packet at cycle 0 -> router receives packets in order 0, 1, 3 with no interleaving; `grant_id` sequence 0, 1, 3.
- Backpressure: `noc_ready` toggles 1-0-1-0 during a 4-flit packet -> each flit is held stable while `noc_ready`=0, no flit lost or duplicated, `stall_cnt` stays 0.
- Protocol error: requester 1 presents a body flit while IDLE -> `err_proto`=1 next cycle; requester 2's head is still granted and delivered.
- Timeout: TIMEOUT=8, requester 0 sends a head then drops `req_valid` for 8 cycles -> `err_timeout`=1 on the 8th cycle, `busy` stays 1, and the later tail is accepted normally.
- Reset mid-packet: assert `rstn`=0 after the body flit -> all outputs at reset values within the same cycle; after release, a new packet from requester 3 is granted first.
